// File: rtl/cg_rvarch_instr_encoder_if.sv
// ============================================================================
// Module : cg_rvarch_instr_encoder_if
// Brief  : Field-in / word-out handshake bundle for the RV32/RV64 encoder.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface cg_rvarch_instr_encoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  i_valid;
  logic                  o_ready;
  logic [2:0]            i_fmt;
  logic [6:0]            i_opcode;
  logic [4:0]            i_rd;
  logic [4:0]            i_rs1;
  logic [4:0]            i_rs2;
  logic [2:0]            i_funct3;
  logic [6:0]            i_funct7;
  logic [DATA_WIDTH-1:0] i_imm;
  logic                  o_valid;
  logic                  i_ready;
  logic [31:0]           o_instr;
  logic [2:0]            o_err;
  logic [CNT_WIDTH-1:0]  o_cnt_ok;
  logic [CNT_WIDTH-1:0]  o_cnt_err;

  modport master (
    output i_valid, i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_ready,
    input  o_ready, o_valid, o_instr, o_err, o_cnt_ok, o_cnt_err
  );

  modport slave (
    input  i_valid, i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_ready,
    output o_ready, o_valid, o_instr, o_err, o_cnt_ok, o_cnt_err
  );
endinterface

`default_nettype wire

// File: rtl/cg_rvarch_instr_encoder.sv
// ============================================================================
// Module : cg_rvarch_instr_encoder
// Brief  : 2-stage valid/ready packer of decoded fields into a 32-bit base-ISA
//          word, with immediate range/alignment flags and saturating counters.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cg_rvarch_instr_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  cg_rvarch_instr_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic        s1_vld_q;
  logic [2:0]  fmt_q;
  logic [6:0]  opcode_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  funct3_q;
  logic [6:0]  funct7_q;
  logic [31:0] imm_q;
  logic [2:0]  err1_q, err1_d;

  logic        s2_vld_q;
  logic [31:0] instr_q, instr_d;
  logic [2:0]  err2_q;

  logic [CNT_WIDTH-1:0] cnt_ok_q, cnt_err_q;

  logic w_s2_load, w_accept, w_deliver;
  logic w_fit12, w_fit13, w_fit21, w_u_oor;

  assign w_s2_load  = !s2_vld_q || bus.i_ready;
  assign bus.o_ready = !s1_vld_q || w_s2_load;
  assign w_accept   = bus.i_valid && bus.o_ready;
  assign w_deliver  = s2_vld_q && bus.i_ready;

  // A signed value fits N bits when everything from bit N-1 upward is one sign.
  assign w_fit12 = (&bus.i_imm[DATA_WIDTH-1:11]) || !(|bus.i_imm[DATA_WIDTH-1:11]);
  assign w_fit13 = (&bus.i_imm[DATA_WIDTH-1:12]) || !(|bus.i_imm[DATA_WIDTH-1:12]);
  assign w_fit21 = (&bus.i_imm[DATA_WIDTH-1:20]) || !(|bus.i_imm[DATA_WIDTH-1:20]);

  generate
    if (DATA_WIDTH > 32) begin : g_u_range
      assign w_u_oor = !((&bus.i_imm[DATA_WIDTH-1:31]) || !(|bus.i_imm[DATA_WIDTH-1:31]));
    end else begin : g_u_norange
      assign w_u_oor = 1'b0;
    end
  endgenerate

  always_comb begin
    err1_d = 3'b000;
    case (bus.i_fmt)
      FMT_R: err1_d = 3'b000;
      FMT_I, FMT_S: err1_d[0] = !w_fit12;
      FMT_B: begin
        err1_d[0] = !w_fit13;
        err1_d[1] = bus.i_imm[0];
      end
      FMT_J: begin
        err1_d[0] = !w_fit21;
        err1_d[1] = bus.i_imm[0];
      end
      FMT_U: begin
        err1_d[0] = w_u_oor;
        err1_d[1] = |bus.i_imm[11:0];
      end
      default: err1_d[2] = 1'b1;
    endcase
  end

  always_comb begin
    instr_d = 32'h0;
    case (fmt_q)
      FMT_R: instr_d = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
      FMT_I: instr_d = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
      FMT_S: instr_d = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
      FMT_B: instr_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                        imm_q[4:1], imm_q[11], opcode_q};
      FMT_U: instr_d = {imm_q[31:12], rd_q, opcode_q};
      FMT_J: instr_d = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
      default: instr_d = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld_q <= 1'b0;
      fmt_q    <= 3'd0;
      opcode_q <= 7'd0;
      rd_q     <= 5'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      funct3_q <= 3'd0;
      funct7_q <= 7'd0;
      imm_q    <= 32'd0;
      err1_q   <= 3'd0;
    end else if (w_accept) begin
      s1_vld_q <= 1'b1;
      fmt_q    <= bus.i_fmt;
      opcode_q <= bus.i_opcode;
      rd_q     <= bus.i_rd;
      rs1_q    <= bus.i_rs1;
      rs2_q    <= bus.i_rs2;
      funct3_q <= bus.i_funct3;
      funct7_q <= bus.i_funct7;
      imm_q    <= bus.i_imm[31:0];
      err1_q   <= err1_d;
    end else if (w_s2_load) begin
      s1_vld_q <= 1'b0;
    end
  end

  // Output word only changes when a new word moves in, so it holds under stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_vld_q <= 1'b0;
      instr_q  <= 32'h0;
      err2_q   <= 3'd0;
    end else if (w_s2_load) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        instr_q <= instr_d;
        err2_q  <= err1_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else if (w_deliver) begin
      if (err2_q == 3'd0) begin
        if (!(&cnt_ok_q)) cnt_ok_q <= cnt_ok_q + 1'b1;
      end else begin
        if (!(&cnt_err_q)) cnt_err_q <= cnt_err_q + 1'b1;
      end
    end
  end

  assign bus.o_valid   = s2_vld_q;
  assign bus.o_instr   = instr_q;
  assign bus.o_err     = err2_q;
  assign bus.o_cnt_ok  = cnt_ok_q;
  assign bus.o_cnt_err = cnt_err_q;

endmodule

`default_nettype wire
